// File: rtl/taxi_display.sv
// taxi_display: converts the meter's money/distance words to BCD with a shift-add-3
// engine and time-multiplexes the eight digits onto an active-low 7-segment bus.
module taxi_display #(
   parameter int SCAN_DIV = 50000,
   parameter int SCAN_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] money,
   input  logic [12:0] distance,
   output logic [7:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [12:0]       m_bin, d_bin, last_m, last_d;
   logic [15:0]       m_bcd, d_bcd, disp_m, disp_d;
   logic [3:0]        bit_cnt;
   logic [SCAN_W-1:0] pre;
   logic [2:0]        idx, idx_nxt;
   logic              wrap;
   logic [28:0]       m_sh, d_sh;
   logic [3:0]        nib;
   logic              blank;

   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   // One double-dabble step: adjust nibbles, then shift {bcd,bin} left by one
   assign m_sh = {add3(m_bcd), m_bin} << 1;
   assign d_sh = {add3(d_bcd), d_bin} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         m_bin   <= '0;
         d_bin   <= '0;
         m_bcd   <= '0;
         d_bcd   <= '0;
         last_m  <= '0;
         last_d  <= '0;
         disp_m  <= '0;
         disp_d  <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ({money, distance} != {last_m, last_d}) begin
                  m_bin   <= money;
                  d_bin   <= distance;
                  last_m  <= money;
                  last_d  <= distance;
                  m_bcd   <= '0;
                  d_bcd   <= '0;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               m_bcd   <= m_sh[28:13];
               m_bin   <= m_sh[12:0];
               d_bcd   <= d_sh[28:13];
               d_bin   <= d_sh[12:0];
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd12) state <= DONE;
            end
            DONE: begin
               disp_m <= m_bcd;
               disp_d <= d_bcd;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scan outputs are computed from the index value being loaded this edge
   assign wrap    = (pre == SCAN_W'(SCAN_DIV - 1));
   assign idx_nxt = wrap ? idx + 3'd1 : idx;

   always_comb begin
      nib   = 4'd0;
      blank = 1'b0;
      case (idx_nxt)
         3'd0: nib = disp_d[3:0];
         3'd1: nib = disp_d[7:4];
         3'd2: begin
            nib   = disp_d[11:8];
            blank = (disp_d[15:8] == 8'd0);
         end
         3'd3: begin
            nib   = disp_d[15:12];
            blank = (disp_d[15:12] == 4'd0);
         end
         3'd4: nib = disp_m[3:0];
         3'd5: nib = disp_m[7:4];
         3'd6: nib = disp_m[11:8];
         default: begin
            nib   = disp_m[15:12];
            blank = (disp_m[15:12] == 4'd0);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         idx   <= '0;
         an_n  <= 8'hFF;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         pre   <= wrap ? '0 : pre + SCAN_W'(1);
         idx   <= idx_nxt;
         an_n  <= ~(8'h01 << idx_nxt);
         seg_n <= blank ? 7'h7F : seg_code(nib);
         dp_n  <= !((idx_nxt == 3'd1) || (idx_nxt == 3'd6));
      end
   end

endmodule

// File: tb/tb_taxi_display.sv
// Directed bench for taxi_display: conversion timing, digit content, blanking and scan walk.
module tb_taxi_display;
   localparam int SCAN_DIV = 4;
   localparam int SCAN_W   = 4;

   localparam logic [6:0] BL = 7'h7F, S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                          S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00,
                          S9 = 7'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] money = '0;
   logic [12:0] distance = '0;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] seg_seen[8];
   logic       dp_seen[8];
   logic       seen[8];

   always #5 clk = ~clk;

   taxi_display #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
      .clk(clk), .rst_n(rst_n), .money(money), .distance(distance),
      .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .busy(busy)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Records the segments/dp shown for each digit over more than one full scan round
   task automatic grab();
      logic [7:0] sel;
      for (int i = 0; i < 8; i++) begin
         seen[i] = 1'b0; seg_seen[i] = BL; dp_seen[i] = 1'b1;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            sel = 8'hFF ^ (8'h01 << i);
            if (an_n === sel) begin
               seen[i] = 1'b1; seg_seen[i] = seg_n; dp_seen[i] = dp_n;
            end
         end
      end
   endtask

   task automatic wait_conv(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40 && busy !== 1'b1; c++) @(negedge clk);
      if (busy !== 1'b1) return;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) @(negedge clk);
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; money = 13'd600; distance = 13'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (an_n !== 8'hFF) $display("FAIL reset_an: got %h, required ff", an_n);
      else n_pass++;
      n_checks++;
      if ({seg_n, dp_n, busy} !== {7'h7F, 1'b1, 1'b0})
         $display("FAIL reset_seg: got seg=%h dp=%b busy=%b, required 7f 1 0", seg_n, dp_n, busy);
      else n_pass++;
   endtask

   task automatic test_first_conv();
      int hi;
      logic [6:0] e[8];
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (an_n !== 8'hFE) $display("FAIL first_scan_an: got %h, required fe", an_n);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL first_busy_rise: got %b, required 1", busy);
      else n_pass++;
      hi = 1;
      for (int c = 0; c < 40 && busy === 1'b1; c++) begin
         @(negedge clk);
         if (busy === 1'b1) hi++;
      end
      n_checks++;
      if (hi !== 14) $display("FAIL busy_len: got %0d cycles, required 14", hi);
      else n_pass++;
      grab();
      e = '{S0, S0, BL, BL, S0, S0, S6, BL};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i] || seg_seen[i] !== e[i] || dp_seen[i] !== ((i == 1 || i == 6) ? 1'b0 : 1'b1))
            $display("FAIL m600_dig%0d: got seen=%b seg=%h dp=%b, required seg=%h", i, seen[i], seg_seen[i], dp_seen[i], e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_max();
      bit ok;
      logic [6:0] e[8];
      money = 13'd8191; distance = 13'd8191;
      wait_conv(ok);
      n_checks++;
      if (!ok) $display("FAIL max_conv: got timeout, required completion");
      else n_pass++;
      grab();
      e = '{S1, S9, S1, S8, S1, S9, S1, S8};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i] || seg_seen[i] !== e[i] || dp_seen[i] !== ((i == 1 || i == 6) ? 1'b0 : 1'b1))
            $display("FAIL max_dig%0d: got seen=%b seg=%h dp=%b, required seg=%h", i, seen[i], seg_seen[i], dp_seen[i], e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_change_mid();
      bit ok;
      int k;
      logic [7:0] sel;
      logic [6:0] e600[8];
      logic [6:0] e720[8];
      e600 = '{S0, S0, BL, BL, S0, S0, S6, BL};
      e720 = '{S0, S0, BL, BL, S0, S2, S7, BL};
      money = 13'd600; distance = 13'd0;
      repeat (5) @(negedge clk);
      money = 13'd720;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mid_busy_gap: got %b, required 0", busy);
      else n_pass++;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (busy !== 1'b1) $display("FAIL mid_second_start: got %b, required 1", busy);
            else n_pass++;
         end
         k = -1;
         for (int i = 0; i < 8; i++) begin
            sel = 8'hFF ^ (8'h01 << i);
            if (an_n === sel) k = i;
         end
         n_checks++;
         if (k < 0) $display("FAIL mid_first_an: got %h, required one-hot low", an_n);
         else if (seg_n !== e600[k]) $display("FAIL mid_first_dig%0d: got %h, required %h", k, seg_n, e600[k]);
         else n_pass++;
      end
      wait_conv(ok);
      n_checks++;
      if (!ok) $display("FAIL mid_second_conv: got timeout, required completion");
      else n_pass++;
      grab();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i] || seg_seen[i] !== e720[i])
            $display("FAIL m720_dig%0d: got seen=%b seg=%h, required %h", i, seen[i], seg_seen[i], e720[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stable();
      int bh, run, trans;
      logic [7:0] prev;
      bh = 0; run = 0; trans = 0;
      prev = an_n;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (busy === 1'b1) bh++;
         if (an_n !== prev) begin
            if (trans < 16) begin
               n_checks++;
               if (an_n !== {prev[6:0], prev[7]}) $display("FAIL walk_next: got %h after %h, required %h", an_n, prev, {prev[6:0], prev[7]});
               else n_pass++;
               if (trans > 0) begin
                  n_checks++;
                  if (run !== SCAN_DIV) $display("FAIL walk_dwell: got %0d cycles on %h, required %0d", run, prev, SCAN_DIV);
                  else n_pass++;
               end
            end
            trans++; run = 1; prev = an_n;
         end else run++;
      end
      n_checks++;
      if (bh !== 0) $display("FAIL stable_busy: got %0d busy cycles, required 0", bh);
      else n_pass++;
      n_checks++;
      if (trans !== 250) $display("FAIL walk_count: got %0d transitions, required 250", trans);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [6:0] e[8];
      money = 13'd1234; distance = 13'd0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (an_n !== 8'hFF) $display("FAIL rmid_an: got %h, required ff", an_n);
      else n_pass++;
      n_checks++;
      if ({seg_n, dp_n, busy} !== {7'h7F, 1'b1, 1'b0})
         $display("FAIL rmid_seg: got seg=%h dp=%b busy=%b, required 7f 1 0", seg_n, dp_n, busy);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL rmid_reconvert: got %b, required 1", busy);
      else n_pass++;
      wait_conv(ok);
      n_checks++;
      if (!ok) $display("FAIL rmid_conv: got timeout, required completion");
      else n_pass++;
      grab();
      e = '{S0, S0, BL, BL, S4, S3, S2, S1};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i] || seg_seen[i] !== e[i])
            $display("FAIL m1234_dig%0d: got seen=%b seg=%h, required %h", i, seen[i], seg_seen[i], e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_dist305();
      bit ok;
      logic [6:0] e[8];
      distance = 13'd305;
      wait_conv(ok);
      n_checks++;
      if (!ok) $display("FAIL d305_conv: got timeout, required completion");
      else n_pass++;
      grab();
      e = '{S5, S0, S3, BL, S4, S3, S2, S1};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i] || seg_seen[i] !== e[i] || dp_seen[i] !== ((i == 1 || i == 6) ? 1'b0 : 1'b1))
            $display("FAIL d305_dig%0d: got seen=%b seg=%h dp=%b, required seg=%h", i, seen[i], seg_seen[i], dp_seen[i], e[i]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_conv();
      test_max();
      test_change_mid();
      test_stable();
      test_reset_mid();
      test_dist305();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
